// File: rtl/arb_pkg.sv
// Shared definitions for the parametrised priority arbiter.
// Mode encoding is common to the top and to any consumer that drives the mode pin.
package arb_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/prio_pick.sv
// Combinational rotating priority pick: highest set bit of req after rotating by start.
// With start = 0 this is a plain highest-index-wins encoder.
module prio_pick #(
    parameter int unsigned N    = 16,
    parameter int unsigned IDXW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] start,
    output logic            found,
    output logic [IDXW-1:0] idx
);

    logic [N-1:0]    rot;
    logic [IDXW:0]   src;
    logic [IDXW-1:0] pos;
    logic [IDXW:0]   sum;

    // rot[j] = req[(j + start) mod N], so rot[N-1] is requester start-1 (searched first).
    always_comb begin
        rot = '0;
        src = '0;
        for (int j = 0; j < N; j++) begin
            src = (IDXW+1)'(j) + {1'b0, start};
            if (src >= (IDXW+1)'(N)) begin
                src = src - (IDXW+1)'(N);
            end
            rot[j] = req[src[IDXW-1:0]];
        end
    end

    always_comb begin
        pos   = '0;
        found = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (rot[j]) begin
                pos   = IDXW'(j);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        sum = {1'b0, pos} + {1'b0, start};
        if (sum >= (IDXW+1)'(N)) begin
            sum = sum - (IDXW+1)'(N);
        end
        idx = sum[IDXW-1:0];
    end

endmodule

// File: rtl/param_priority_arbiter.sv
// Registered N-input priority arbiter with fixed / round-robin modes and a
// valid/ready output slot; reports winner index, one-hot grant and request popcount.
module param_priority_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned N    = 16,
    parameter int unsigned IDXW = $clog2(N),
    parameter int unsigned CNTW = $clog2(N + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            mode,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IDXW-1:0] out_idx,
    output logic [N-1:0]    out_grant,
    output logic [CNTW-1:0] out_count
);

    logic            valid_q, valid_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [IDXW-1:0] ptr_q, ptr_d;

    logic            slot_free;
    logic [IDXW-1:0] start;
    logic            pick_found;
    logic [IDXW-1:0] pick_idx;
    logic [CNTW-1:0] req_count;

    assign slot_free = !valid_q || out_ready;
    assign start     = (mode == MODE_RR) ? ptr_q : '0;

    prio_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_pick (
        .req   (req),
        .start (start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        req_count = '0;
        for (int i = 0; i < N; i++) begin
            req_count = req_count + CNTW'(req[i]);
        end
    end

    // Stall holds everything; a free slot with no requests only drops valid.
    always_comb begin
        valid_d = valid_q;
        idx_d   = idx_q;
        grant_d = grant_q;
        count_d = count_q;
        ptr_d   = ptr_q;
        if (slot_free) begin
            if (pick_found) begin
                valid_d = 1'b1;
                idx_d   = pick_idx;
                grant_d = N'(1) << pick_idx;
                count_d = req_count;
                if (mode == MODE_RR) begin
                    ptr_d = pick_idx;
                end
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            grant_q <= '0;
            count_q <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
            count_q <= count_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = valid_q;
    assign out_idx   = idx_q;
    assign out_grant = grant_q;
    assign out_count = count_q;

endmodule

// File: tb/tb_param_priority_arbiter.sv
// Self-checking bench for param_priority_arbiter (N = 16): directed plan steps
// followed by random traffic, all checked against a search-order reference model.
module tb_param_priority_arbiter;

    localparam int N = 16;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic        mode;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_idx;
    logic [15:0] out_grant;
    logic [4:0]  out_count;

    int n_cmp;
    int n_err;

    // Reference model state
    logic        m_valid;
    int          m_idx;
    logic [15:0] m_grant;
    int          m_count;
    int          m_ptr;

    param_priority_arbiter #(
        .N (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_grant (out_grant),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Walk the priority order directly: descending from N-1 (fixed) or from ptr-1 (RR).
    function automatic int winner(input logic [15:0] r, input logic m, input int p);
        int c;
        for (int k = 1; k <= N; k++) begin
            c = m ? (p - k + 2 * N) % N : N - k;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_idx   = 0;
        m_grant = '0;
        m_count = 0;
        m_ptr   = 0;
    endtask

    task automatic model_edge(input logic [15:0] r, input logic m, input logic rdy);
        int w;
        if (!m_valid || rdy) begin
            if (r != 0) begin
                w       = winner(r, m, m_ptr);
                m_valid = 1'b1;
                m_idx   = w;
                m_grant = 16'h1 << w;
                m_count = $countones(r);
                if (m) m_ptr = w;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 64'(out_valid), 64'(m_valid));
        chk({tag, ".idx"},   64'(out_idx),   64'(m_idx));
        chk({tag, ".grant"}, 64'(out_grant), 64'(m_grant));
        chk({tag, ".count"}, 64'(out_count), 64'(m_count));
    endtask

    // Drive inputs away from the edge, advance one clock, check 1 time unit later.
    task automatic step(input string tag, input logic [15:0] r, input logic m,
                        input logic rdy);
        req       = r;
        mode      = m;
        out_ready = rdy;
        @(posedge clk);
        model_edge(r, m, rdy);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [15:0] rr;
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        req       = '0;
        mode      = 1'b0;
        out_ready = 1'b1;
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        step("idle0", 16'h0000, 1'b0, 1'b1);
        step("idle1", 16'h0000, 1'b0, 1'b1);
        chk("idle.valid_const", 64'(out_valid), 64'd0);

        step("fixed90", 16'h0090, 1'b0, 1'b1);
        chk("fixed90.idx_const",   64'(out_idx),   64'd7);
        chk("fixed90.grant_const", 64'(out_grant), 64'h80);
        chk("fixed90.count_const", 64'(out_count), 64'd2);

        for (int i = 0; i < 17; i++) begin
            step("rr_full", 16'hFFFF, 1'b1, 1'b1);
            chk("rr_full.idx_const",   64'(out_idx),   64'((i < 16) ? 15 - i : 15));
            chk("rr_full.count_const", 64'(out_count), 64'd16);
            chk("rr_full.onehot",      64'($countones(out_grant)), 64'd1);
        end

        step("rr81.first", 16'h0081, 1'b1, 1'b1);
        chk("rr81.first_const", 64'(out_idx), 64'd7);
        for (int i = 0; i < 3; i++) begin
            step("rr81.stall", 16'h0081, 1'b1, 1'b0);
            chk("rr81.stall_const", 64'(out_idx), 64'd7);
        end
        step("rr81.resume", 16'h0081, 1'b1, 1'b1);
        chk("rr81.resume_const", 64'(out_idx), 64'd0);
        step("rr81.next", 16'h0081, 1'b1, 1'b1);
        chk("rr81.next_const", 64'(out_idx), 64'd7);

        step("sw.rr3", 16'h0008, 1'b1, 1'b1);
        chk("sw.rr3_const", 64'(out_idx), 64'd3);
        step("sw.fixed", 16'h000F, 1'b0, 1'b1);
        chk("sw.fixed_const", 64'(out_idx), 64'd3);
        step("sw.rr", 16'h000F, 1'b1, 1'b1);
        chk("sw.rr_const", 64'(out_idx), 64'd2);

        step("zero_hold", 16'h0000, 1'b1, 1'b1);
        chk("zero_hold.idx_const", 64'(out_idx), 64'd2);

        step("ar.cap", 16'h0100, 1'b1, 1'b1);
        step("ar.stall", 16'h0100, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("ar.valid_async", 64'(out_valid), 64'd0);
        check_all("ar.async");
        @(negedge clk);
        rst = 1'b0;
        step("ar.after", 16'h0001, 1'b1, 1'b1);
        chk("ar.after_const", 64'(out_idx), 64'd0);
        step("ar.sole", 16'h0001, 1'b1, 1'b1);
        chk("ar.sole_const", 64'(out_idx), 64'd0);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       rr = 16'h0000;
                1:       rr = 16'(1 << $urandom_range(0, 15));
                2:       rr = 16'($urandom());
                default: rr = 16'($urandom() & $urandom() & $urandom());
            endcase
            step("rand", rr, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
